// File: rtl/mdu_pkg.sv
// Shared types and operation-class helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_READ_HI  = 4'd0,
    OP_READ_LO  = 4'd1,
    OP_WRITE_HI = 4'd2,
    OP_WRITE_LO = 4'd3,
    OP_MUL      = 4'd4,
    OP_MULU     = 4'd5,
    OP_DIV      = 4'd6,
    OP_DIVU     = 4'd7,
    OP_MADD     = 4'd8,
    OP_MADDU    = 4'd9,
    OP_MSUB     = 4'd10,
    OP_MSUBU    = 4'd11
  } mdu_op_t;

  // Codes 12..15 are not enumerated; they decode as no-ops everywhere.
  typedef logic [1:0] mdu_state_t;

  localparam mdu_state_t ST_IDLE     = 2'd0;
  localparam mdu_state_t ST_MUL_WAIT = 2'd1;
  localparam mdu_state_t ST_DIV_ITER = 2'd2;
  localparam mdu_state_t ST_DIV_FIX  = 2'd3;

  function automatic logic is_mul_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_MUL, OP_MULU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_DIV, OP_DIVU: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_acc_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_MUL, OP_DIV, OP_MADD, OP_MSUB: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_iterative_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, WIDTH cycles after load.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  // Partial remainder shifted left with the next dividend bit, and the trial subtraction.
  // Bit WIDTH of the difference is the borrow: set when the divisor does not fit.
  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;
  logic           fits_s;

  // Trial subtraction for the current restoring step.
  always_comb begin
    shifted_s = {rem_q, quo_q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dvs_q};
    fits_s    = ~diff_s[WIDTH];
  end

  // Next-state: abort beats load, load beats stepping.
  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = done_q;
    if (abort) begin
      cnt_d    = {CNT_W{1'b0}};
      active_d = 1'b0;
      done_d   = 1'b0;
    end else if (load) begin
      rem_d    = {WIDTH{1'b0}};
      quo_d    = dividend;
      dvs_d    = divisor;
      cnt_d    = CNT_W'(WIDTH);
      active_d = 1'b1;
      done_d   = 1'b0;
    end else if (active_q) begin
      rem_d = fits_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], fits_s};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end else begin
        active_d = 1'b1;
      end
    end else begin
      done_d = done_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q    <= {WIDTH{1'b0}};
      quo_q    <= {WIDTH{1'b0}};
      dvs_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/mdu_iterative.sv
// Multiply/divide unit with HI/LO: fixed-latency multiply(-accumulate), iterative divide, cancel.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [3:0]       operation,
  input  logic             start,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] data_read
);

  localparam int CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             quot_neg_q, quot_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             div_zero_q, div_zero_d;

  logic             accept_s;
  logic             div_load_s;
  logic             div_abort_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic [WIDTH-1:0] div_quo_s;
  logic [WIDTH-1:0] div_rem_s;
  logic             div_done_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] ext_b_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] mul_res_s;

  assign busy        = (state_q != ST_IDLE);
  assign accept_s    = (state_q == ST_IDLE) && start && !cancel;
  assign div_load_s  = accept_s && is_div_op(operation);
  assign div_abort_s = cancel && (state_q != ST_IDLE);

  // Operand magnitudes for signed divide; DIVU passes the raw values through.
  always_comb begin
    if (is_signed_op(operation) && operand1[WIDTH-1]) begin
      dvd_mag_s = {WIDTH{1'b0}} - operand1;
    end else begin
      dvd_mag_s = operand1;
    end
    if (is_signed_op(operation) && operand2[WIDTH-1]) begin
      dvs_mag_s = {WIDTH{1'b0}} - operand2;
    end else begin
      dvs_mag_s = operand2;
    end
  end

  mdu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clock    (clock),
    .reset    (reset),
    .load     (div_load_s),
    .abort    (div_abort_s),
    .dividend (dvd_mag_s),
    .divisor  (dvs_mag_s),
    .quotient (div_quo_s),
    .remainder(div_rem_s),
    .done     (div_done_s)
  );

  // Sign correction applied in DIV_FIX: quotient negative when signs differ, remainder follows dividend.
  always_comb begin
    quo_fix_s = quot_neg_q ? ({WIDTH{1'b0}} - div_quo_s) : div_quo_s;
    rem_fix_s = rem_neg_q  ? ({WIDTH{1'b0}} - div_rem_s) : div_rem_s;
  end

  // Full-width product of the latched operands; the latency counter gives retiming room.
  always_comb begin
    if (is_signed_op(op_q)) begin
      ext_a_s = {{WIDTH{opa_q[WIDTH-1]}}, opa_q};
      ext_b_s = {{WIDTH{opb_q[WIDTH-1]}}, opb_q};
    end else begin
      ext_a_s = {{WIDTH{1'b0}}, opa_q};
      ext_b_s = {{WIDTH{1'b0}}, opb_q};
    end
    prod_s = ext_a_s * ext_b_s;
  end

  // Multiply result, optionally accumulated into or subtracted from {HI,LO} modulo 2^(2*WIDTH).
  always_comb begin
    if (is_acc_op(op_q)) begin
      if ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) begin
        mul_res_s = {hi_q, lo_q} - prod_s;
      end else begin
        mul_res_s = {hi_q, lo_q} + prod_s;
      end
    end else begin
      mul_res_s = prod_s;
    end
  end

  // Control FSM and HI/LO next-state; cancel always wins over a commit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d  = operation;
          opa_d = operand1;
          opb_d = operand2;
          if (is_mul_op(operation)) begin
            state_d = ST_MUL_WAIT;
            cnt_d   = CNT_W'(MUL_LATENCY);
          end else if (is_div_op(operation)) begin
            state_d    = ST_DIV_ITER;
            cnt_d      = CNT_W'(WIDTH);
            quot_neg_d = is_signed_op(operation) && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
            rem_neg_d  = is_signed_op(operation) && operand1[WIDTH-1];
            div_zero_d = (operand2 == {WIDTH{1'b0}});
          end else if (operation == OP_WRITE_HI) begin
            hi_d = operand1;
          end else if (operation == OP_WRITE_LO) begin
            lo_d = operand1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL_WAIT: begin
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_W'(1)) begin
          state_d      = ST_IDLE;
          cnt_d        = {CNT_W{1'b0}};
          {hi_d, lo_d} = mul_res_s;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV_ITER: begin
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DIV_FIX;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV_FIX: begin
        state_d = ST_IDLE;
        if (cancel) begin
          cnt_d = {CNT_W{1'b0}};
        end else if (div_done_s && !div_zero_q) begin
          hi_d = rem_fix_s;
          lo_d = quo_fix_s;
        end else begin
          cnt_d = {CNT_W{1'b0}};
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter, HI/LO and latched-operand registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      op_q       <= 4'd0;
      opa_q      <= {WIDTH{1'b0}};
      opb_q      <= {WIDTH{1'b0}};
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      op_q       <= op_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Read port: combinational view of the current HI/LO.
  always_comb begin
    case (operation)
      OP_READ_HI: data_read = hi_q;
      OP_READ_LO: data_read = lo_q;
      default:    data_read = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: driver pushes expected reads and busy lengths, monitor checks.
module tb_mdu_iterative;
  import mdu_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 5;

  logic          clock;
  logic          reset;
  logic [W-1:0]  operand1;
  logic [W-1:0]  operand2;
  logic [3:0]    operation;
  logic          start;
  logic          cancel;
  logic          busy;
  logic [W-1:0]  data_read;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  logic [W-1:0] rd_q[$];
  string        rd_name_q[$];
  int           dur_q[$];
  int           busy_run = 0;

  mdu_iterative #(.WIDTH(W), .MUL_LATENCY(LAT)) dut (
    .clock    (clock),
    .reset    (reset),
    .operand1 (operand1),
    .operand2 (operand2),
    .operation(operation),
    .start    (start),
    .cancel   (cancel),
    .busy     (busy),
    .data_read(data_read)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: busy-length and read-value checks, sampled on the falling edge.
  always @(negedge clock) begin
    logic [W-1:0] exp_v;
    int           exp_d;
    string        nm;
    if (busy === 1'b1) begin
      busy_run = busy_run + 1;
    end else if (busy_run > 0) begin
      n_chk = n_chk + 1;
      if (dur_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL busy_len: got %0d cycles, none expected", busy_run);
      end else begin
        exp_d = dur_q.pop_front();
        if (busy_run != exp_d) begin
          n_err = n_err + 1;
          $display("FAIL busy_len: got %0d cycles, expected %0d", busy_run, exp_d);
        end
      end
      busy_run = 0;
    end
    if (operation == OP_READ_HI || operation == OP_READ_LO) begin
      n_chk = n_chk + 1;
      if (rd_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL read: got %h, no expected value queued", data_read);
      end else begin
        exp_v = rd_q.pop_front();
        nm    = rd_name_q.pop_front();
        if (data_read !== exp_v) begin
          n_err = n_err + 1;
          $display("FAIL %s: got %h, expected %h", nm, data_read, exp_v);
        end
      end
    end
  end

  // Reference model: HI/LO effect of one completed operation, in plain arithmetic.
  task automatic model_apply(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] acc;
    logic [63:0] prod;
    int sa;
    int sb;
    sa   = $signed(a);
    sb   = $signed(b);
    acc  = {m_hi, m_lo};
    if (op == OP_MUL || op == OP_MADD || op == OP_MSUB) prod = longint'(sa) * longint'(sb);
    else prod = {32'd0, a} * {32'd0, b};
    case (op)
      OP_WRITE_HI: m_hi = a;
      OP_WRITE_LO: m_lo = a;
      OP_MUL, OP_MULU: {m_hi, m_lo} = prod;
      OP_MADD, OP_MADDU: {m_hi, m_lo} = acc + prod;
      OP_MSUB, OP_MSUBU: {m_hi, m_lo} = acc - prod;
      OP_DIV: begin
        if (b == 32'd0) begin
          m_hi = m_hi;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'd0;
        end else begin
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end
      end
      OP_DIVU: begin
        if (b != 32'd0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      default: m_hi = m_hi;
    endcase
  endtask

  // Issue a read in the current cycle; the monitor checks it against the model.
  task automatic do_read(input logic hi_sel, input string nm);
    start     = 1'b0;
    operation = hi_sel ? OP_READ_HI : OP_READ_LO;
    rd_q.push_back(hi_sel ? m_hi : m_lo);
    rd_name_q.push_back(nm);
    @(posedge clock); #1;
    operation = 4'd12;
  endtask

  task automatic read_both(input string nm);
    do_read(1'b1, {nm, "_hi"});
    do_read(1'b0, {nm, "_lo"});
  endtask

  // Issue one operation; optionally cancel/reset in busy cycle N, or inject starts mid-multiply.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int cancel_at, input int reset_at, input bit inject);
    bit is_mul;
    bit is_div;
    int k;
    is_mul = op inside {OP_MUL, OP_MULU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    is_div = op inside {OP_DIV, OP_DIVU};
    if (is_mul || is_div) begin
      if (cancel_at > 0) dur_q.push_back(cancel_at);
      else if (reset_at > 0) dur_q.push_back(reset_at);
      else dur_q.push_back(is_mul ? LAT : W + 1);
    end
    if (reset_at > 0) begin
      m_hi = '0;
      m_lo = '0;
    end else if (cancel_at == 0) begin
      model_apply(op, a, b);
    end
    operation = op;
    operand1  = a;
    operand2  = b;
    start     = 1'b1;
    @(posedge clock); #1;
    start     = 1'b0;
    operation = 4'd12;
    if (inject) begin
      @(posedge clock); #1;
      start = 1'b1; operation = OP_MULU; operand1 = $urandom; operand2 = $urandom;
      @(posedge clock); #1;
      operation = OP_WRITE_LO; operand1 = 32'd9;
      @(posedge clock); #1;
      start = 1'b0; operation = 4'd12;
    end
    if (cancel_at > 0) begin
      repeat (cancel_at - 1) begin @(posedge clock); #1; end
      cancel = 1'b1;
      @(posedge clock); #1;
      cancel = 1'b0;
    end
    if (reset_at > 0) begin
      repeat (reset_at - 1) begin @(posedge clock); #1; end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
    end
    k = 0;
    while (busy !== 1'b0 && k < 100) begin
      @(posedge clock); #1;
      k = k + 1;
    end
    n_chk = n_chk + 1;
    if (k >= 100) begin
      n_err = n_err + 1;
      $display("FAIL busy_timeout: busy still %b after %0d cycles, expected 0", busy, k);
    end
  endtask

  initial begin
    logic [3:0]   ops[10];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0]   rop;
    ops = '{OP_MUL, OP_MULU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
            OP_WRITE_HI, OP_WRITE_LO};
    reset = 1'b1; start = 1'b0; cancel = 1'b0;
    operation = 4'd12; operand1 = '0; operand2 = '0;
    repeat (3) @(posedge clock);
    #1; reset = 1'b0;

    n_chk = n_chk + 1;
    if (busy !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset_busy: got %b, expected 0", busy);
    end
    read_both("reset");

    do_op(OP_MUL, 32'hFFFF_FFFE, 32'd3, 0, 0, 1'b0);
    read_both("mul_neg");
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
    read_both("div_neg7_2");
    do_op(OP_WRITE_HI, 32'h1234, 32'd0, 0, 0, 1'b0);
    do_read(1'b1, "write_hi_next");
    do_op(OP_WRITE_LO, 32'h1234, 32'd0, 0, 0, 1'b0);
    do_op(OP_DIVU, 32'd7, 32'd0, 0, 0, 1'b0);
    read_both("divu_by0");
    do_op(OP_WRITE_HI, 32'd0, 32'd0, 0, 0, 1'b0);
    do_op(OP_WRITE_LO, 32'hFFFF_FFFF, 32'd0, 0, 0, 1'b0);
    do_op(OP_MADDU, 32'd1, 32'd1, 0, 0, 1'b0);
    read_both("maddu_carry");
    do_op(OP_WRITE_LO, 32'd0, 32'd0, 0, 0, 1'b0);
    do_op(OP_WRITE_HI, 32'd0, 32'd0, 0, 0, 1'b0);
    do_op(OP_MSUB, 32'd2, 32'd3, 0, 0, 1'b0);
    read_both("msub_from0");
    do_op(OP_WRITE_HI, 32'd5, 32'd0, 0, 0, 1'b0);
    do_op(OP_WRITE_LO, 32'd5, 32'd0, 0, 0, 1'b0);
    do_op(OP_DIV, 32'd100, 32'd7, 3, 0, 1'b0);
    read_both("div_cancel");
    do_op(OP_MUL, 32'd11, 32'd13, LAT, 0, 1'b0);
    read_both("mul_cancel_commit");
    do_op(OP_MULU, 32'hDEAD_BEEF, 32'h0000_1234, 0, 0, 1'b1);
    read_both("mulu_ignore_start");
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
    read_both("div_overflow");
    do_op(OP_MUL, 32'd77, 32'd99, 0, 2, 1'b0);
    read_both("mul_reset");

    for (int i = 0; i < 40; i++) begin
      rop = ops[$urandom_range(0, 9)];
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      do_op(rop, ra, rb, 0, 0, 1'b0);
      read_both("rand");
    end

    repeat (3) begin @(posedge clock); #1; end
    n_chk = n_chk + 1;
    if (rd_q.size() != 0 || dur_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL scoreboard_drain: reads left %0d, busy lengths left %0d, expected 0",
               rd_q.size(), dur_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
